// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch squash and halt drain,
// all with parameterised lengths. Drives PC/IF-ID hold, IF-ID flush and ID-EX bubble.
module hazard_ctrl #(
   parameter int         INSTR_W     = 16,
   parameter int         REG_W       = 4,
   parameter int         LOAD_STALL  = 1,
   parameter int         BR_FLUSH    = 2,
   parameter int         HALT_DRAIN  = 3,
   parameter logic [3:0] HLT_OP      = 4'hF,
   parameter int         ZERO_REG_HW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] if_id_instr,
   input  logic [INSTR_W-1:0] id_ex_instr,
   input  logic               id_ex_memread,
   input  logic               branch_taken,
   output logic               stall,
   output logic               flush_if_id,
   output logic               flush_id_ex,
   output logic               hlt,
   output logic               busy
);

   localparam int MAX_CNT = (LOAD_STALL > BR_FLUSH)
                            ? ((LOAD_STALL > HALT_DRAIN) ? LOAD_STALL : HALT_DRAIN)
                            : ((BR_FLUSH > HALT_DRAIN) ? BR_FLUSH : HALT_DRAIN);
   localparam int CNT_W = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(BR_FLUSH - 1);
   localparam logic [CNT_W-1:0] HD_LOAD = CNT_W'(HALT_DRAIN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [2:0] S_RUN    = 3'd0;
   localparam logic [2:0] S_LSTALL = 3'd1;
   localparam logic [2:0] S_BFLUSH = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [REG_W-1:0] ex_rd;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             is_halt;
   logic             load_use;
   logic             unused_bits;

   assign ex_rd   = id_ex_instr[3*REG_W-1 -: REG_W];
   assign id_rs   = if_id_instr[2*REG_W-1 -: REG_W];
   assign id_rt   = if_id_instr[REG_W-1:0];
   assign is_halt = (if_id_instr[INSTR_W-1 -: 4] == HLT_OP);

   // Writes to register 0 are discarded in hardware, so they cannot create a dependency.
   assign load_use = id_ex_memread && ((ex_rd == id_rs) || (ex_rd == id_rt))
                     && ((ZERO_REG_HW == 0) || (ex_rd != '0));

   // Remaining instruction bits carry no hazard information.
   assign unused_bits = ^{if_id_instr, id_ex_instr};

   // NOTE: every output and next-state signal gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall       = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      case (state_q)
         S_RUN, S_LSTALL: begin
            if (branch_taken) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               state_d     = (BR_FLUSH > 1) ? S_BFLUSH : S_RUN;
               cnt_d       = (BR_FLUSH > 1) ? BR_LOAD : '0;
            end else if (state_q == S_LSTALL) begin
               stall       = 1'b1;
               flush_id_ex = 1'b1;
               state_d     = (cnt_q <= CNT_ONE) ? S_RUN : S_LSTALL;
               cnt_d       = (cnt_q <= CNT_ONE) ? '0 : cnt_q - CNT_ONE;
            end else if (is_halt) begin
               stall   = 1'b1;
               state_d = S_DRAIN;
               cnt_d   = HD_LOAD;
            end else if (load_use) begin
               stall       = 1'b1;
               flush_id_ex = 1'b1;
               state_d     = (LOAD_STALL > 1) ? S_LSTALL : S_RUN;
               cnt_d       = (LOAD_STALL > 1) ? LS_LOAD : '0;
            end
         end
         S_BFLUSH: begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = (cnt_q <= CNT_ONE) ? S_RUN : S_BFLUSH;
            cnt_d       = (cnt_q <= CNT_ONE) ? '0 : cnt_q - CNT_ONE;
         end
         S_DRAIN: begin
            // Halt is committed once decoded; a late branch cannot cancel it.
            stall   = 1'b1;
            state_d = (cnt_q == '0) ? S_HALTED : S_DRAIN;
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
         end
         S_HALTED: begin
            stall = 1'b1;
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hlt  = (state_q == S_HALTED);
   assign busy = (state_q != S_RUN);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default, LOAD_STALL=3 and ZERO_REG_HW=0 instances
// share one stimulus stream; each scenario starts from reset.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] if_id_instr;
   logic [15:0] id_ex_instr;
   logic        id_ex_memread;
   logic        branch_taken;

   logic d_stall, d_fif, d_fex, d_hlt, d_busy;
   logic l_stall, l_fif, l_fex, l_hlt, l_busy;
   logic z_stall, z_fif, z_fex, z_hlt, z_busy;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl u_dut (
      .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr),
      .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
      .stall(d_stall), .flush_if_id(d_fif), .flush_id_ex(d_fex), .hlt(d_hlt), .busy(d_busy)
   );

   hazard_ctrl #(.LOAD_STALL(3)) u_dut_ls3 (
      .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr),
      .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
      .stall(l_stall), .flush_if_id(l_fif), .flush_id_ex(l_fex), .hlt(l_hlt), .busy(l_busy)
   );

   hazard_ctrl #(.ZERO_REG_HW(0)) u_dut_nz (
      .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .id_ex_instr(id_ex_instr),
      .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
      .stall(z_stall), .flush_if_id(z_fif), .flush_id_ex(z_fex), .hlt(z_hlt), .busy(z_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_id_instr   = 16'h0000;
      id_ex_instr   = 16'h0000;
      id_ex_memread = 1'b0;
      branch_taken  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      step();
      rst = 1'b1;
   endtask

   // Hazard for one cycle (the bubble then replaces the load in ID/EX).
   task automatic load_use_seq(input string pfx);
      id_ex_memread = 1'b1;
      id_ex_instr   = 16'h8310;
      if_id_instr   = 16'h2034;
      @(negedge clk);
      check({pfx, "_c1_stall"}, d_stall, 1);
      check({pfx, "_c1_fex"},   d_fex, 1);
      check({pfx, "_c1_fif"},   d_fif, 0);
      check({pfx, "_c1_ls3"},   l_stall, 1);
      step();
      id_ex_memread = 1'b0;
      @(negedge clk);
      check({pfx, "_c2_stall"},     d_stall, 0);
      check({pfx, "_c2_fex"},       d_fex, 0);
      check({pfx, "_c2_ls3_stall"}, l_stall, 1);
      check({pfx, "_c2_ls3_fex"},   l_fex, 1);
      check({pfx, "_c2_ls3_busy"},  l_busy, 1);
      step();
      @(negedge clk);
      check({pfx, "_c3_ls3_stall"}, l_stall, 1);
      step();
      @(negedge clk);
      check({pfx, "_c4_ls3_stall"}, l_stall, 0);
      check({pfx, "_c4_ls3_busy"},  l_busy, 0);
   endtask

   // Halt decode in the current cycle; optional branch pulse one cycle later.
   task automatic halt_seq(input string pfx, input logic with_branch);
      if_id_instr = 16'hF000;
      @(negedge clk);
      check({pfx, "_dec_stall"}, d_stall, 1);
      check({pfx, "_dec_fif"},   d_fif, 0);
      for (int e = 1; e <= 4; e++) begin
         step();
         branch_taken = with_branch && (e == 1);
         @(negedge clk);
         check($sformatf("%s_e%0d_hlt", pfx, e),   d_hlt, (e == 4));
         check($sformatf("%s_e%0d_stall", pfx, e), d_stall, 1);
         check($sformatf("%s_e%0d_busy", pfx, e),  d_busy, 1);
         check($sformatf("%s_e%0d_fif", pfx, e),   d_fif, 0);
         check($sformatf("%s_e%0d_fex", pfx, e),   d_fex, 0);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      #1;
      check("rst_stall", d_stall, 0);
      check("rst_fif",   d_fif, 0);
      check("rst_fex",   d_fex, 0);
      check("rst_hlt",   d_hlt, 0);
      check("rst_busy",  d_busy, 0);

      do_reset();
      load_use_seq("lu");

      // Destination register 0
      do_reset();
      id_ex_memread = 1'b1;
      id_ex_instr   = 16'h8010;
      if_id_instr   = 16'h2004;
      @(negedge clk);
      check("zr_hw1_stall", d_stall, 0);
      check("zr_hw1_fex",   d_fex, 0);
      check("zr_hw0_stall", z_stall, 1);
      check("zr_hw0_fex",   z_fex, 1);
      step();
      id_ex_memread = 1'b0;
      @(negedge clk);
      check("zr_hw0_c2_stall", z_stall, 0);

      // Branch wins over a simultaneous load-use
      do_reset();
      id_ex_memread = 1'b1;
      id_ex_instr   = 16'h8310;
      if_id_instr   = 16'h2034;
      branch_taken  = 1'b1;
      @(negedge clk);
      check("br_c1_fif",   d_fif, 1);
      check("br_c1_fex",   d_fex, 1);
      check("br_c1_stall", d_stall, 0);
      step();
      idle_inputs();
      @(negedge clk);
      check("br_c2_fif",   d_fif, 1);
      check("br_c2_fex",   d_fex, 1);
      check("br_c2_stall", d_stall, 0);
      check("br_c2_busy",  d_busy, 1);
      step();
      @(negedge clk);
      check("br_c3_fif",  d_fif, 0);
      check("br_c3_fex",  d_fex, 0);
      check("br_c3_busy", d_busy, 0);

      // Halt drain, then sticky hlt under arbitrary inputs
      do_reset();
      halt_seq("hd", 1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         if_id_instr   = 16'($urandom);
         id_ex_instr   = 16'($urandom);
         id_ex_memread = 1'($urandom);
         branch_taken  = 1'($urandom);
         @(negedge clk);
         check($sformatf("sticky%0d_hlt", i),   d_hlt, 1);
         check($sformatf("sticky%0d_stall", i), d_stall, 1);
      end

      // Branch during drain is ignored
      do_reset();
      halt_seq("bd", 1'b1);

      // Asynchronous reset during LSTALL
      do_reset();
      id_ex_memread = 1'b1;
      id_ex_instr   = 16'h8310;
      if_id_instr   = 16'h2034;
      step();
      idle_inputs();
      @(negedge clk);
      check("rl_pre_stall", l_stall, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rl_stall", l_stall, 0);
      check("rl_fex",   l_fex, 0);
      check("rl_busy",  l_busy, 0);
      rst = 1'b1;
      step();
      load_use_seq("rl_lu");

      // Asynchronous reset during DRAIN
      do_reset();
      if_id_instr = 16'hF000;
      step();
      if_id_instr = 16'h0000;
      @(negedge clk);
      check("rd_pre_busy", d_busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rd_stall", d_stall, 0);
      check("rd_busy",  d_busy, 0);
      check("rd_hlt",   d_hlt, 0);
      rst = 1'b1;
      step();
      load_use_seq("rd_lu");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller between the IF/ID and ID/EX pipeline registers. It detects load-use data hazards, squashes wrong-path instructions on a taken branch, and sequences a halt through a pipeline drain. Every stall, bubble and drain length is a parameter rather than a fixed count. Its outputs drive the PC write-enable, the IF/ID hold/flush and the ID/EX bubble insert.

## Interface
- INSTR_W, 16: instruction width; must be >= 4 + 3*REG_W
- REG_W, 4: register-specifier width
- LOAD_STALL, 1: bubble cycles per load-use hazard (>= 1)
- BR_FLUSH, 2: squash cycles per taken branch (>= 1)
- HALT_DRAIN, 3: cycles from halt decode to hlt assertion (>= 1)
- HLT_OP, 4'hF: halt opcode
- ZERO_REG_HW, 1: when 1, destination register 0 never causes a hazard

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately
- if_id_instr  in  INSTR_W  instruction in decode
- id_ex_instr  in  INSTR_W  instruction in execute
- id_ex_memread  in  1  execute-stage instruction is a load
- branch_taken  in  1  execute-stage branch resolved taken (single-cycle pulse)
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  squash IF/ID contents
- flush_id_ex  out  1  insert bubble into ID/EX
- hlt  out  1  processor halted; sticky until reset
- busy  out  1  FSM not in RUN

## Operation
- Field map, MSB first:
  - opcode = [INSTR_W-1 -: 4]
  - rd = [3*REG_W-1 -: REG_W]
  - rs = [2*REG_W-1 -: REG_W]
  - rt = [REG_W-1:0]
- Load destination is id_ex_instr.rd.
- Load-use condition: id_ex_memread & (rd == if_id.rs | rd == if_id.rt), and additionally rd != 0 when ZERO_REG_HW = 1.
- FSM states RUN, LSTALL, BFLUSH, DRAIN, HALTED. Priority in RUN: branch_taken > halt decode > load-use.
- RUN:
  - branch_taken: flush_if_id = flush_id_ex = 1 combinationally. If BR_FLUSH > 1, go to BFLUSH with counter = BR_FLUSH-1. A halt or load-use in ID that same cycle is ignored (wrong path).
  - opcode == HLT_OP: stall = 1 and flush_if_id = 0. Go to DRAIN with counter = HALT_DRAIN-1.
  - load-use: stall = flush_id_ex = 1 combinationally. If LOAD_STALL > 1, go to LSTALL with counter = LOAD_STALL-1.
- LSTALL:
  - stall = flush_id_ex = 1; counter decrements each cycle; leave to RUN when the counter reaches 1.
  - branch_taken aborts to the RUN branch action (flush_if_id = flush_id_ex = 1). With BR_FLUSH > 1 the FSM then goes to BFLUSH.
- BFLUSH: flush_if_id = flush_id_ex = 1 and stall = 0; decrement; return to RUN after the last cycle.
- DRAIN:
  - stall = 1. branch_taken is ignored because halt is non-speculative once decoded.
  - Decrement; when the counter is 0 at the clock edge, enter HALTED.
- HALTED: hlt = stall = 1; no exit except reset.
- busy = (state != RUN).
- Counter width is clog2(max(LOAD_STALL, BR_FLUSH, HALT_DRAIN)+1). Counters never wrap; they saturate at 0.

## Timing
- Reset (rst = 0, asynchronous): state = RUN, counter = 0, and hlt = busy = 0. Combinational outputs follow the inputs in RUN.
- A reset asserted mid-stall or mid-drain aborts immediately. No output glitches high after rst falls.
- Load-use latency:
  - stall is asserted in the detection cycle (Mealy) and held for exactly LOAD_STALL cycles total.
  - A second hazard detected in the cycle after return to RUN re-stalls; this is legal.
- Branch: flush outputs are high for exactly BR_FLUSH consecutive cycles, starting in the branch_taken cycle.
- Halt: hlt rises exactly HALT_DRAIN+1 rising edges after the first edge at which an HLT_OP instruction in ID was sampled in RUN. stall is continuous from the decode cycle onward.
- A repeated HLT_OP held in IF/ID does not restart the drain; only RUN→DRAIN loads the counter.

## Test plan
- Load-use, defaults: id_ex_memread = 1, id_ex_instr = 16'h8310 (rd = 3), if_id_instr = 16'h2034 (rs = 3). Required: stall = flush_id_ex = 1 for 1 cycle, then 0. With LOAD_STALL = 3, the same stimulus gives exactly 3 cycles.
- Zero register: same stimulus with rd = 0 and rs = 0 gives no stall when ZERO_REG_HW = 1, and a 1-cycle stall when ZERO_REG_HW = 0.
- Branch vs hazard: branch_taken = 1 in the same cycle as the load-use condition. Required: flush_if_id = flush_id_ex = 1 for 2 cycles and stall = 0 throughout.
- Halt drain: if_id_instr = 16'hF000 held. Required: stall = 1 from the decode cycle, hlt = 1 on the 4th rising edge, and busy = 1 throughout. hlt stays 1 for 20 further cycles with arbitrary inputs.
- Branch during drain: branch_taken pulsed 1 cycle after halt decode. Required: it is ignored, with no flush outputs and hlt on the same edge as the halt-drain case.
- Reset mid-operation: drop rst during LSTALL and during DRAIN. Required: outputs go to 0 and busy = 0 immediately, without waiting for a clock edge. After release, a new hazard behaves as in the load-use test.
